// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the SDRAM port arbiter: geometry defaults and FSM state encodings.
package sdram_port_arbiter_pkg;

  localparam int SDR_SDRAM_ROW_SIZE   = 12;
  localparam int SDR_SDRAM_COL_SIZE   = 8;
  localparam int SDR_SDRAM_DATA_WIDTH = 16;
  localparam int SDR_ARB_TAG_DEPTH    = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_DONE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sdram_port_arbiter_tag_fifo.sv
// In-order FIFO of port IDs for outstanding reads; head steers returning read data.
module sdram_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the single-port SDRAM controller among NPORTS requesters,
// with an in-order tag FIFO steering read data back to the issuing port.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int NPORTS      = 4,
  parameter int ADDR_W      = SDR_SDRAM_ROW_SIZE + SDR_SDRAM_COL_SIZE,
  parameter int DATA_W      = SDR_SDRAM_DATA_WIDTH,
  parameter int TAG_DEPTH   = SDR_ARB_TAG_DEPTH,
  parameter int GNT_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        p_req_i,
  input  logic [NPORTS-1:0]        p_we_i,
  input  logic [NPORTS*ADDR_W-1:0] p_addr_i,
  input  logic [NPORTS*DATA_W-1:0] p_wdata_i,
  output logic [NPORTS-1:0]        p_gnt_o,
  output logic [NPORTS-1:0]        p_rvalid_o,
  output logic [DATA_W-1:0]        p_rdata_o,
  output logic                     wr_req_o,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic [DATA_W-1:0]        wr_data_o,
  input  logic                     wr_gnt_i,
  output logic                     rd_req_o,
  output logic [ADDR_W-1:0]        rd_addr_o,
  input  logic                     rd_gnt_i,
  input  logic [DATA_W-1:0]        rd_data_i,
  input  logic                     rd_valid_i,
  output logic                     err_o
);

  localparam int PW = $clog2(NPORTS);
  localparam int TW = $clog2(GNT_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(GNT_TIMEOUT - 1);

  // First eligible port strictly after 'last', wrapping; MSB of the result flags a hit.
  function automatic logic [PW:0] rr_pick(input logic [NPORTS-1:0] elig,
                                          input logic [PW-1:0]     last);
    logic [PW:0] res;
    int          j;
    res = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      j = (int'(last) + k) % NPORTS;
      if (!res[PW] && elig[PW'(j)]) res = {1'b1, PW'(j)};
    end
    return res;
  endfunction

  arb_state_e          state_q, state_d;
  logic [PW-1:0]       last_q, last_d;
  logic [PW-1:0]       win_q, win_d;
  logic                we_q, we_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                wr_req_q, wr_req_d;
  logic                rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [NPORTS-1:0]   p_gnt_q, p_gnt_d;
  logic [NPORTS-1:0]   p_rvalid_q, p_rvalid_d;
  logic [DATA_W-1:0]   p_rdata_q, p_rdata_d;
  logic                err_q, err_d;

  logic [NPORTS-1:0]   eligible;
  logic [PW:0]         pick;
  logic [PW-1:0]       sel;
  logic                gnt_ok;
  logic                tmo_err;
  logic                tag_push, tag_pop, tag_full, tag_empty;
  logic [PW-1:0]       tag_head;

  assign eligible = p_req_i & (tag_full ? p_we_i : {NPORTS{1'b1}});
  assign pick     = rr_pick(eligible, last_q);
  assign sel      = pick[PW-1:0];
  assign gnt_ok   = we_q ? wr_gnt_i : rd_gnt_i;

  assign tag_pop  = rd_valid_i && !tag_empty;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    we_d      = we_q;
    tmo_d     = tmo_q;
    wr_req_d  = wr_req_q;
    rd_req_d  = rd_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    p_gnt_d   = '0;
    tag_push  = 1'b0;
    tmo_err   = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick[PW]) begin
          win_d   = sel;
          we_d    = p_we_i[sel];
          tmo_d   = '0;
          state_d = ARB_ISSUE;
          if (p_we_i[sel]) begin
            wr_req_d  = 1'b1;
            wr_addr_d = p_addr_i[sel*ADDR_W +: ADDR_W];
            wr_data_d = p_wdata_i[sel*DATA_W +: DATA_W];
          end else begin
            rd_req_d  = 1'b1;
            rd_addr_d = p_addr_i[sel*ADDR_W +: ADDR_W];
          end
        end
      end
      ARB_ISSUE: begin
        if (gnt_ok) begin
          wr_req_d       = 1'b0;
          rd_req_d       = 1'b0;
          last_d         = win_q;
          tag_push       = !we_q;
          p_gnt_d[win_q] = 1'b1;
          tmo_d          = '0;
          state_d        = ARB_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // Abort without granting; the requester still holds its request and is retried.
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          last_d   = win_q;
          tmo_err  = 1'b1;
          tmo_d    = '0;
          state_d  = ARB_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase

    p_rvalid_d = '0;
    if (tag_pop) p_rvalid_d[tag_head] = 1'b1;
    p_rdata_d = tag_pop ? rd_data_i : p_rdata_q;
    err_d     = tmo_err || (rd_valid_i && tag_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      last_q     <= PW'(NPORTS - 1);
      win_q      <= '0;
      we_q       <= 1'b0;
      tmo_q      <= '0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      p_gnt_q    <= '0;
      p_rvalid_q <= '0;
      p_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      we_q       <= we_d;
      tmo_q      <= tmo_d;
      wr_req_q   <= wr_req_d;
      rd_req_q   <= rd_req_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
      p_gnt_q    <= p_gnt_d;
      p_rvalid_q <= p_rvalid_d;
      p_rdata_q  <= p_rdata_d;
      err_q      <= err_d;
    end
  end

  sdram_tag_fifo #(
    .W     (PW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tag_push),
    .din_i   (win_q),
    .pop_i   (tag_pop),
    .dout_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  assign p_gnt_o    = p_gnt_q;
  assign p_rvalid_o = p_rvalid_q;
  assign p_rdata_o  = p_rdata_q;
  assign wr_req_o   = wr_req_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign rd_req_o   = rd_req_q;
  assign rd_addr_o  = rd_addr_q;
  assign err_o      = err_q;

endmodule
